// File: rtl/dt_pkg.sv
// Shared types and constants for the decision tree trainer and its classifier.
package dt_pkg;

  localparam int DT_FEAT_W = 3;
  localparam int DT_NLEAF  = 2 ** DT_FEAT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_ACCUM,
    ST_RESOLVE,
    ST_DONE
  } dt_state_e;

endpackage

// File: rtl/dt_vote_counter.sv
// One leaf's pair of saturating vote counters (label 0 and label 1).
module dt_vote_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc0,
  input  logic             inc1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Flags an increment that was swallowed because the counter was already full.
  assign sat = (inc0 && (cnt0 == CNT_MAX)) || (inc1 && (cnt1 == CNT_MAX));

  // NOTE: sequential state uses non-blocking assignments so every counter
  // updates from the same pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (inc0 && (cnt0 != CNT_MAX)) cnt0 <= cnt0 + 1'b1;
      if (inc1 && (cnt1 != CNT_MAX)) cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: rtl/decision_tree_trainer.sv
// Learns the classifier's leaf prediction table by per-leaf majority vote.
// Optional DT_TRAINER_SPARSE_EN forces under-sampled leaves to 0 and reports them.
module decision_tree_trainer
  import dt_pkg::*;
#(
  parameter int FEAT_W      = DT_FEAT_W,
  parameter int CNT_W       = 8,
  parameter int MIN_SAMPLES = 2,
  localparam int NLEAF      = 2 ** FEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              commit,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FEAT_W-1:0] s_features,
  input  logic              s_label,
  output logic              busy,
  output logic              done,
  output logic              table_valid,
  output logic [NLEAF-1:0]  pred_table,
  output logic              sat
`ifdef DT_TRAINER_SPARSE_EN
  ,
  output logic [NLEAF-1:0]  sparse_mask
`endif
);

  localparam logic [FEAT_W-1:0] LAST_LEAF = FEAT_W'(NLEAF - 1);

  dt_state_e         state_q, state_d;
  logic [FEAT_W-1:0] k_q;
  logic [CNT_W-1:0]  cnt0 [NLEAF];
  logic [CNT_W-1:0]  cnt1 [NLEAF];
  logic [NLEAF-1:0]  leaf_sat;
  logic              accept;
  logic              clr;
  logic              leaf_pred;

  // A restart in ACCUM drops the sample presented alongside it.
  assign accept = (state_q == ST_ACCUM) && s_valid && !start;
  assign clr    = (state_q == ST_CLEAR);

  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    logic hit;
    assign hit = accept && (s_features == FEAT_W'(i));

    dt_vote_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .inc0 (hit && !s_label),
      .inc1 (hit && s_label),
      .cnt0 (cnt0[i]),
      .cnt1 (cnt1[i]),
      .sat  (leaf_sat[i])
    );
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (start)       state_d = ST_CLEAR;
        else if (commit) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: if (k_q == LAST_LEAF) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

`ifdef DT_TRAINER_SPARSE_EN
  localparam logic [CNT_W:0] MIN_SUM = (CNT_W + 1)'(MIN_SAMPLES);

  logic [CNT_W:0] leaf_sum;
  logic           leaf_sparse;

  always_comb begin
    leaf_sum    = {1'b0, cnt0[k_q]} + {1'b0, cnt1[k_q]};
    leaf_sparse = (leaf_sum < MIN_SUM);
    leaf_pred   = (cnt1[k_q] > cnt0[k_q]) && !leaf_sparse;
  end
`else
  assign leaf_pred = (cnt1[k_q] > cnt0[k_q]);
`endif

  // Handshake/status outputs are registered from the next state so they
  // line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      s_ready     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      table_valid <= 1'b0;
      pred_table  <= '0;
      sat         <= 1'b0;
`ifdef DT_TRAINER_SPARSE_EN
      sparse_mask <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_ready <= (state_d == ST_ACCUM);
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);

      if (clr) begin
        sat         <= 1'b0;
        table_valid <= 1'b0;
`ifdef DT_TRAINER_SPARSE_EN
        sparse_mask <= '0;
`endif
      end else begin
        if (|leaf_sat)            sat         <= 1'b1;
        if (state_d == ST_DONE)   table_valid <= 1'b1;
      end

      if (state_q == ST_RESOLVE) begin
        k_q             <= k_q + 1'b1;
        pred_table[k_q] <= leaf_pred;
`ifdef DT_TRAINER_SPARSE_EN
        sparse_mask[k_q] <= leaf_sparse;
`endif
      end else begin
        k_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_decision_tree_trainer.sv
// Self-checking bench for decision_tree_trainer (CNT_W = 4); honours DT_TRAINER_SPARSE_EN.
module tb_decision_tree_trainer;
  import dt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       commit = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [2:0] s_features = '0;
  logic       s_label = 1'b0;
  logic       busy, done, table_valid, sat;
  logic [7:0] pred_table;
`ifdef DT_TRAINER_SPARSE_EN
  logic [7:0] sparse_mask;
`endif

  always #5 clk = ~clk;

  decision_tree_trainer #(.FEAT_W(3), .CNT_W(4), .MIN_SAMPLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .commit     (commit),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_features (s_features),
    .s_label    (s_label),
    .busy       (busy),
    .done       (done),
    .table_valid(table_valid),
    .pred_table (pred_table),
    .sat        (sat)
`ifdef DT_TRAINER_SPARSE_EN
    ,
    .sparse_mask(sparse_mask)
`endif
  );

  typedef struct {
    logic [7:0] pred;
    logic [7:0] mask;
    logic       sat;
  } exp_t;

  typedef struct {
    int   ones  [8];
    int   zeros [8];
    exp_t exp;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q [$];
  vec_t vecs [5];
  logic [7:0] last_pred;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [7:0] pd, input logic [7:0] ps,
                              input logic [7:0] mask, input logic s);
    exp_t e;
`ifdef DT_TRAINER_SPARSE_EN
    e.pred = ps;
    e.mask = mask;
`else
    e.pred = pd;
    e.mask = 8'h00;
`endif
    e.sat = s;
    return e;
  endfunction

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("s_ready_in_accum", s_ready, 1'b1);
  endtask

  task automatic send(input logic [2:0] f, input logic l);
    s_valid = 1'b1; s_features = f; s_label = l;
    tick();
    s_valid = 1'b0;
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  // Commit (optionally with a sample in the same cycle), then scoreboard the result.
  task automatic finish_session(input exp_t e, input bit with_sample,
                                input logic [2:0] f, input logic l);
    int   cycles;
    bit   ready_seen;
    exp_t got_exp;
    commit = 1'b1;
    if (with_sample) begin
      s_valid = 1'b1; s_features = f; s_label = l;
    end
    exp_q.push_back(e);
    tick();
    commit = 1'b0;
    // Keep offering a sample through RESOLVE/DONE; it must never be taken.
    s_valid = 1'b1; s_features = 3'd2; s_label = 1'b1;
    cycles = 1;
    ready_seen = 1'b0;
    while (!done && cycles < 20) begin
      if (s_ready) ready_seen = 1'b1;
      tick();
      cycles++;
    end
    if (s_ready) ready_seen = 1'b1;
    s_valid = 1'b0;
    check("commit_to_done_latency", cycles, 9);
    check("s_ready_low_resolve", ready_seen, 1'b0);
    got_exp = exp_q.pop_front();
    if (done) begin
      check("pred_table", pred_table, got_exp.pred);
      check("sat", sat, got_exp.sat);
      check("table_valid", table_valid, 1'b1);
`ifdef DT_TRAINER_SPARSE_EN
      check("sparse_mask", sparse_mask, got_exp.mask);
`endif
      last_pred = got_exp.pred;
    end
    tick();
    check("done_single_pulse", done, 1'b0);
    check("busy_idle_after_done", busy, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    start_session();
    for (int leaf = 0; leaf < 8; leaf++) begin
      for (int n = 0; n < v.ones[leaf]; n++)  send(3'(leaf), 1'b1);
      for (int n = 0; n < v.zeros[leaf]; n++) send(3'(leaf), 1'b0);
    end
    finish_session(v.exp, 1'b0, 3'd0, 1'b0);
  endtask

  initial begin
    vecs[0].ones  = '{3, 0, 0, 0, 0, 0, 0, 0};
    vecs[0].zeros = '{1, 0, 0, 2, 0, 0, 0, 0};
    vecs[0].exp   = mk(8'h01, 8'h01, 8'hF6, 1'b0);
    vecs[1].ones  = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1].zeros = '{0, 0, 0, 0, 0, 1, 0, 0};
    vecs[1].exp   = mk(8'h00, 8'h00, 8'hDF, 1'b0);
    vecs[2].ones  = '{0, 0, 0, 0, 0, 0, 0, 20};
    vecs[2].zeros = '{0, 0, 0, 0, 0, 0, 0, 1};
    vecs[2].exp   = mk(8'h80, 8'h80, 8'h7F, 1'b1);
    vecs[3].ones  = '{0, 2, 0, 0, 5, 0, 4, 0};
    vecs[3].zeros = '{0, 1, 3, 0, 5, 0, 0, 0};
    vecs[3].exp   = mk(8'h42, 8'h42, 8'hA9, 1'b0);
    vecs[4].ones  = '{0, 0, 0, 0, 0, 0, 15, 0};
    vecs[4].zeros = '{0, 0, 0, 0, 0, 0, 16, 0};
    vecs[4].exp   = mk(8'h00, 8'h00, 8'hBF, 1'b1);

    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_table_valid", table_valid, 1'b0);
    check("rst_pred_table", pred_table, 8'h00);
    check("rst_sat", sat, 1'b0);
    rst_n = 1'b1;
    tick();

    // IDLE ignores commit and samples.
    commit = 1'b1; s_valid = 1'b1;
    tick();
    commit = 1'b0; s_valid = 1'b0;
    tick();
    check("idle_ignores_commit", busy, 1'b0);
    check("idle_s_ready", s_ready, 1'b0);

    for (int v = 0; v < 5; v++) run_vec(vecs[v]);

    // Table persists in IDLE.
    repeat (4) tick();
    check("idle_table_hold", pred_table, last_pred);
    check("idle_table_valid_hold", table_valid, 1'b1);

    // Sample arriving with commit is counted.
    start_session();
    finish_session(mk(8'h04, 8'h00, 8'hFF, 1'b0), 1'b1, 3'd2, 1'b1);

    // Restart from ACCUM discards earlier votes and the simultaneous sample.
    start_session();
    repeat (3) send(3'd1, 1'b1);
    start = 1'b1; s_valid = 1'b1; s_features = 3'd2; s_label = 1'b1;
    tick();
    start = 1'b0; s_valid = 1'b0;
    check("restart_clear_busy", busy, 1'b1);
    check("restart_clears_valid", table_valid, 1'b0);
    tick();
    check("restart_s_ready", s_ready, 1'b1);
    send(3'd3, 1'b1);
    send(3'd3, 1'b1);
    finish_session(mk(8'h08, 8'h08, 8'hF7, 1'b0), 1'b0, 3'd0, 1'b0);

    // Reset in the third RESOLVE cycle.
    start_session();
    send(3'd0, 1'b1);
    send(3'd0, 1'b1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    tick();
    check("resolve_busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_pred_table", pred_table, 8'h00);
    check("midrst_table_valid", table_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_done", done, 1'b0);
    tick();
    run_vec(vecs[0]);

    // Single sample leaf, then a two-sample leaf.
    start_session();
    send(3'd4, 1'b1);
    finish_session(mk(8'h10, 8'h00, 8'hFF, 1'b0), 1'b0, 3'd0, 1'b0);
    start_session();
    send(3'd4, 1'b1);
    send(3'd4, 1'b1);
    finish_session(mk(8'h10, 8'h10, 8'hEF, 1'b0), 1'b0, 3'd0, 1'b0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
